// File: rtl/light_pkg.sv
// Shared constants and frame helpers for the LED write arbiter and its pattern engine.
package light_pkg;

    // Pattern modes
    localparam logic [1:0] LIGHT_MODE_OFF     = 2'd0;
    localparam logic [1:0] LIGHT_MODE_BLINK   = 2'd1;
    localparam logic [1:0] LIGHT_MODE_MARQUEE = 2'd2;
    localparam logic [1:0] LIGHT_MODE_COUNTER = 2'd3;

    // LED driver half addresses
    localparam logic [1:0] LIGHT_ADDR_LO = 2'b00;
    localparam logic [1:0] LIGHT_ADDR_HI = 2'b10;

    // Pattern sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WR_LO = 2'd1;
    localparam logic [1:0] ST_WR_HI = 2'd2;

    // Frame values loaded when a mode starts
    localparam logic [23:0] FRAME_START_BLINK   = 24'h000000;
    localparam logic [23:0] FRAME_START_MARQUEE = 24'h000001;
    localparam logic [23:0] FRAME_START_COUNTER = 24'h000000;

    function automatic logic [23:0] frame_start(input logic [1:0] mode);
        case (mode)
            LIGHT_MODE_BLINK:   frame_start = FRAME_START_BLINK;
            LIGHT_MODE_MARQUEE: frame_start = FRAME_START_MARQUEE;
            default:            frame_start = FRAME_START_COUNTER;
        endcase
    endfunction

    // Frame advance applied on each pattern tick
    function automatic logic [23:0] frame_step(input logic [1:0] mode, input logic [23:0] frame);
        case (mode)
            LIGHT_MODE_BLINK:   frame_step = ~frame;
            LIGHT_MODE_MARQUEE: frame_step = {frame[22:0], frame[23]};
            LIGHT_MODE_COUNTER: frame_step = frame + 24'd1;
            default:            frame_step = frame;
        endcase
    endfunction

endpackage

// File: rtl/light_tick_prescaler.sv
// Free-running prescaler producing one tick every TICK_DIV cycles while running.
module light_tick_prescaler
    import light_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000,
    localparam int unsigned CNT_W = $clog2(TICK_DIV)
) (
    input  logic iCpuClock,
    input  logic iCpuReset,
    input  logic iClear,
    input  logic iRun,
    output logic oTick
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_end;

    assign at_end = (count_q == CNT_W'(TICK_DIV - 1));
    // A clear outranks a coincident terminal count
    assign oTick  = iRun && !iClear && at_end;

    // Next count: held at zero when stopped or cleared, wraps at the terminal count
    always_comb begin
        count_d = count_q;
        if (!iRun || iClear) begin
            count_d = '0;
        end else if (at_end) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/light_write_arbiter.sv
// Sole master of the LED driver write port: CPU stores pass straight through with absolute
// priority, and a pattern engine fills idle cycles with two-write (low, high) frame updates.
module light_write_arbiter
    import light_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic        iCpuClock,
    input  logic        iCpuReset,
    input  logic        iCpuLedWrite,
    input  logic [1:0]  iCpuLightAddress,
    input  logic [15:0] iCpuLightData,
    input  logic        iPatternEnable,
    input  logic [1:0]  iPatternMode,
    output logic        oDoLedWrite,
    output logic [1:0]  oLightAddress,
    output logic [15:0] oLightDataToWrite,
    output logic        oPatternBusy
);

    logic [1:0]  state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [23:0] frame_q, frame_d;

    logic        engine_on;
    logic        start;
    logic        tick;

    logic        pat_req;
    logic [1:0]  pat_addr;
    logic [15:0] pat_data;

    logic        write_d;
    logic [1:0]  addr_d;
    logic [15:0] data_d;
    logic        busy_d;

    assign engine_on = iPatternEnable && (iPatternMode != LIGHT_MODE_OFF);
    // The stored mode is parked at OFF while the engine is off, so this single compare
    // catches both the off->on transition and a mode change while running.
    assign start     = engine_on && (iPatternMode != mode_q);

    light_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .iCpuClock (iCpuClock),
        .iCpuReset (iCpuReset),
        .iClear    (start),
        .iRun      (engine_on),
        .oTick     (tick)
    );

    // Pattern engine next state and the pattern write request for this cycle
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        frame_d  = frame_q;
        pat_req  = 1'b0;
        pat_addr = LIGHT_ADDR_LO;
        pat_data = frame_q[15:0];
        if (!engine_on) begin
            state_d = ST_IDLE;
            mode_d  = LIGHT_MODE_OFF;
        end else if (start) begin
            state_d = ST_IDLE;
            mode_d  = iPatternMode;
            frame_d = frame_start(iPatternMode);
        end else if (tick) begin
            // Any unfinished frame is dropped in favour of the new one
            state_d = ST_WR_LO;
            frame_d = frame_step(mode_q, frame_q);
        end else begin
            case (state_q)
                ST_WR_LO: begin
                    pat_req  = 1'b1;
                    pat_addr = LIGHT_ADDR_LO;
                    pat_data = frame_q[15:0];
                    if (!iCpuLedWrite) begin
                        state_d = ST_WR_HI;
                    end
                end
                ST_WR_HI: begin
                    pat_req  = 1'b1;
                    pat_addr = LIGHT_ADDR_HI;
                    pat_data = {8'h00, frame_q[23:16]};
                    if (!iCpuLedWrite) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output arbitration: CPU first, then the pattern request; address/data hold when idle
    always_comb begin
        write_d = 1'b0;
        addr_d  = oLightAddress;
        data_d  = oLightDataToWrite;
        if (iCpuLedWrite) begin
            write_d = 1'b1;
            addr_d  = iCpuLightAddress;
            data_d  = iCpuLightData;
        end else if (pat_req) begin
            write_d = 1'b1;
            addr_d  = pat_addr;
            data_d  = pat_data;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Engine state and registered outputs
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            state_q           <= ST_IDLE;
            mode_q            <= LIGHT_MODE_OFF;
            frame_q           <= 24'h000000;
            oDoLedWrite       <= 1'b0;
            oLightAddress     <= 2'b00;
            oLightDataToWrite <= 16'h0000;
            oPatternBusy      <= 1'b0;
        end else begin
            state_q           <= state_d;
            mode_q            <= mode_d;
            frame_q           <= frame_d;
            oDoLedWrite       <= write_d;
            oLightAddress     <= addr_d;
            oLightDataToWrite <= data_d;
            oPatternBusy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_light_write_arbiter.sv
// Directed bench for light_write_arbiter with a queue-based reference model checked every cycle.
module tb_light_write_arbiter;

    localparam int unsigned DIV = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_w;
    logic [1:0]  cpu_a;
    logic [15:0] cpu_d;
    logic        pen;
    logic [1:0]  pmode;
    logic        do_w;
    logic [1:0]  l_addr;
    logic [15:0] l_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Every write the DUT issues, as {addr, data}
    logic [17:0] wlog[$];

    // Reference model state
    logic [1:0]  m_mode;
    int          m_phase;
    int          m_ticks;
    logic [17:0] m_q[$];
    logic        m_valid = 1'b0;
    logic        exp_w;
    logic [1:0]  exp_a;
    logic [15:0] exp_d;
    logic        exp_b;

    always #5 clk = ~clk;

    light_write_arbiter #(
        .TICK_DIV (DIV)
    ) dut (
        .iCpuClock         (clk),
        .iCpuReset         (rst),
        .iCpuLedWrite      (cpu_w),
        .iCpuLightAddress  (cpu_a),
        .iCpuLightData     (cpu_d),
        .iPatternEnable    (pen),
        .iPatternMode      (pmode),
        .oDoLedWrite       (do_w),
        .oLightAddress     (l_addr),
        .oLightDataToWrite (l_data),
        .oPatternBusy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame after a given number of ticks since the mode started
    function automatic logic [23:0] model_frame(input logic [1:0] mode, input int ticks);
        case (mode)
            2'd1:    return (ticks % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            2'd2:    return 24'h000001 << (ticks % 24);
            default: return 24'(ticks);
        endcase
    endfunction

    // Compare last cycle's prediction, then predict the next registered outputs
    always @(negedge clk) begin
        logic        on;
        logic        st;
        logic        tk;
        logic [23:0] f;
        logic [17:0] e;
        if (rst) begin
            m_mode  = 2'd0;
            m_phase = 0;
            m_ticks = 0;
            m_q.delete();
            exp_w   = 1'b0;
            exp_a   = 2'b00;
            exp_d   = 16'h0000;
            exp_b   = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (do_w) wlog.push_back({l_addr, l_data});
            if (m_valid) begin
                check("strobe", {31'd0, do_w}, {31'd0, exp_w});
                check("addr", {30'd0, l_addr}, {30'd0, exp_a});
                check("data", {16'd0, l_data}, {16'd0, exp_d});
                check("busy", {31'd0, busy}, {31'd0, exp_b});
            end
            on = pen && (pmode != 2'd0);
            st = on && (pmode != m_mode);
            tk = 1'b0;
            if (!on) begin
                m_phase = 0;
                m_mode  = 2'd0;
                m_q.delete();
            end else if (st) begin
                m_mode  = pmode;
                m_phase = 0;
                m_ticks = 0;
                m_q.delete();
            end else if (m_phase == int'(DIV) - 1) begin
                tk      = 1'b1;
                m_phase = 0;
                m_ticks++;
                m_q.delete();
                f = model_frame(m_mode, m_ticks);
                m_q.push_back({2'b00, f[15:0]});
                m_q.push_back({2'b10, 8'h00, f[23:16]});
            end else begin
                m_phase++;
            end
            exp_w = 1'b0;
            if (cpu_w) begin
                exp_w = 1'b1;
                exp_a = cpu_a;
                exp_d = cpu_d;
            end else if (!tk && m_q.size() > 0) begin
                e     = m_q.pop_front();
                exp_w = 1'b1;
                exp_a = e[17:16];
                exp_d = e[15:0];
            end
            exp_b = (m_q.size() > 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int found;
        int stale;
        logic [17:0] pat[$];

        rst   = 1'b1;
        cpu_w = 1'b0;
        cpu_a = 2'b00;
        cpu_d = 16'h0000;
        pen   = 1'b0;
        pmode = 2'd0;
        cyc(3);
        check("reset_strobe", {31'd0, do_w}, 32'd0);
        check("reset_addr", {30'd0, l_addr}, 32'd0);
        check("reset_data", {16'd0, l_data}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // CPU passthrough with engine off
        cyc(4);
        cpu_w = 1'b1; cpu_a = 2'b00; cpu_d = 16'hA5A5;
        cyc(1);
        cpu_w = 1'b0; cpu_a = 2'b01; cpu_d = 16'h1234;
        check("cpu_strobe", {31'd0, do_w}, 32'd1);
        check("cpu_addr", {30'd0, l_addr}, 32'd0);
        check("cpu_data", {16'd0, l_data}, 32'h0000A5A5);
        cyc(1);
        check("cpu_idle_strobe", {31'd0, do_w}, 32'd0);
        check("cpu_hold_data", {16'd0, l_data}, 32'h0000A5A5);
        cpu_w = 1'b1;
        cyc(1);
        cpu_w = 1'b0;
        check("cpu_addr01", {30'd0, l_addr}, 32'd1);
        check("cpu_data01", {16'd0, l_data}, 32'h00001234);
        cyc(2);

        // Marquee: 24 ticks walk a single bit through all positions and wrap
        wlog.delete();
        pen = 1'b1; pmode = 2'd2;
        for (int i = 0; i < 400 && wlog.size() < 48; i++) cyc(1);
        check("marquee_count", wlog.size() >= 48 ? 32'd48 : wlog.size(), 32'd48);
        check("marquee_w0", {14'd0, wlog[0]}, {14'd0, 2'b00, 16'h0002});
        check("marquee_w1", {14'd0, wlog[1]}, {14'd0, 2'b10, 16'h0000});
        check("marquee_w45", {14'd0, wlog[45]}, {14'd0, 2'b10, 16'h0080});
        check("marquee_w46", {14'd0, wlog[46]}, {14'd0, 2'b00, 16'h0001});
        check("marquee_w47", {14'd0, wlog[47]}, {14'd0, 2'b10, 16'h0000});
        pen = 1'b0;
        cyc(3);

        // Blink: two CPU stores right after the tick delay the frame but do not lose it
        wlog.delete();
        pen = 1'b1; pmode = 2'd1;
        cyc(DIV + 1);
        cpu_w = 1'b1; cpu_a = 2'b11; cpu_d = 16'h1111;
        cyc(1);
        cpu_d = 16'h2222;
        cyc(1);
        cpu_w = 1'b0;
        check("blink_busy", {31'd0, busy}, 32'd1);
        cyc(3);
        check("blink_count", wlog.size(), 32'd4);
        check("blink_w0", {14'd0, wlog[0]}, {14'd0, 2'b11, 16'h1111});
        check("blink_w1", {14'd0, wlog[1]}, {14'd0, 2'b11, 16'h2222});
        check("blink_w2", {14'd0, wlog[2]}, {14'd0, 2'b00, 16'hFFFF});
        check("blink_w3", {14'd0, wlog[3]}, {14'd0, 2'b10, 16'h00FF});
        pen = 1'b0;
        cyc(3);

        // Counter under CPU saturation: only the newest frame emerges
        wlog.delete();
        pen = 1'b1; pmode = 2'd3;
        cpu_w = 1'b1; cpu_a = 2'b11;
        for (int i = 0; i < 12; i++) begin
            cpu_d = 16'hC000 + 16'(i);
            cyc(1);
        end
        cpu_w = 1'b0;
        cyc(5);
        pat.delete();
        stale = 0;
        foreach (wlog[i]) begin
            if (wlog[i][17:16] != 2'b11) pat.push_back(wlog[i]);
            if (wlog[i] == {2'b00, 16'h0001}) stale++;
        end
        check("counter_pat_count", pat.size(), 32'd2);
        check("counter_lo", {14'd0, pat[0]}, {14'd0, 2'b00, 16'h0002});
        check("counter_hi", {14'd0, pat[1]}, {14'd0, 2'b10, 16'h0000});
        check("counter_stale", stale, 32'd0);
        pen = 1'b0;
        cyc(3);

        // Enable dropped while the high-half write is pending
        wlog.delete();
        pen = 1'b1; pmode = 2'd1;
        cyc(DIV + 2);
        check("drop_lo_strobe", {31'd0, do_w}, 32'd1);
        check("drop_lo_data", {14'd0, l_addr, l_data}, {14'd0, 2'b00, 16'hFFFF});
        pen = 1'b0;
        cyc(1);
        check("drop_strobe", {31'd0, do_w}, 32'd0);
        check("drop_busy", {31'd0, busy}, 32'd0);
        check("drop_prescaler", 32'(dut.u_prescaler.count_q), 32'd0);
        cyc(3);
        check("drop_count", wlog.size(), 32'd1);

        // Reset between the low and high writes of a frame
        wlog.delete();
        pen = 1'b1; pmode = 2'd2;
        cyc(DIV + 2);
        check("rst_pre_lo", {13'd0, do_w, l_addr, l_data}, {13'd0, 1'b1, 2'b00, 16'h0002});
        rst = 1'b1;
        #1;
        check("rst_async_strobe", {31'd0, do_w}, 32'd0);
        check("rst_async_out", {14'd0, l_addr, l_data}, 32'd0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(6);
        check("rst_quiet", wlog.size(), 32'd0);
        cyc(3);
        check("rst_count", wlog.size(), 32'd2);
        check("rst_w0", {14'd0, wlog[0]}, {14'd0, 2'b00, 16'h0002});
        check("rst_w1", {14'd0, wlog[1]}, {14'd0, 2'b10, 16'h0000});
        pen = 1'b0;
        cyc(3);

        found = checks;
        if (found < 12) check("too_few_checks", found, 32'd12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
